// File: rtl/bcd_display_pkg.sv
// Shared types and helpers for the BCD display sequencer.
// Used by bcd_display_ctrl and bcd_shift_add3. The optional blanking output
// of the top level is enabled with `define BCD_DISPLAY_CTRL_BLANK_EN.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // 10^n as a 64-bit constant; NUM_DIGITS tops out at 8, so this never wraps.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Largest value that fits in num_digits decimal digits, clipped to what
  // a bin_w-bit input can express at all.
  function automatic logic [63:0] max_val(input int num_digits, input int bin_w);
    logic [63:0] dec_max;
    logic [63:0] bin_max;
    dec_max = pow10(num_digits) - 64'd1;
    bin_max = (64'd1 << bin_w) - 64'd1;
    return (dec_max < bin_max) ? dec_max : bin_max;
  endfunction

  // Double-dabble nibble correction: a nibble of 5..9 would become >= 10
  // after the next doubling, so pre-add 3 to make it carry correctly.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_shift_add3.sv
// Combinational add-3 correction across every nibble of the BCD register.
// The caller performs the left shift after this stage.
module bcd_shift_add3
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign o_bcd[4*g +: 4] = add3_if_ge5(i_bcd[4*g +: 4]);
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Accepts a binary value over valid/ready, converts it to BCD one bit per
// cycle (shift-add-3), then strobes one digit per cycle into a bank of
// NUM_DIGITS seven-segment decoder units, least-significant digit first.
// Values above 10^NUM_DIGITS-1 raise a sticky overflow and are not written.
// Define BCD_DISPLAY_CTRL_BLANK_EN to add the digit_blank output, which
// marks leading-zero digits so the integrator can blank those units.
module bcd_display_ctrl
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      value_i,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [3:0]            digit_o,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  digit_write,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
  output logic                  digit_blank,
`endif
  output logic                  overflow
);

  localparam int              BCD_W      = 4 * NUM_DIGITS;
  localparam logic [63:0]     MAXVAL     = max_val(NUM_DIGITS, BIN_W);
  localparam int              CNT_MAX    = (BIN_W > NUM_DIGITS) ? BIN_W : NUM_DIGITS;
  localparam int              CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(NUM_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BIN_W-1:0]        r_shift;
  logic [BIN_W-1:0]        w_shift_nxt;
  logic [BCD_W-1:0]        r_bcd;
  logic [BCD_W-1:0]        w_bcd_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [3:0]              r_digit;
  logic [3:0]              w_digit_nxt;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [NUM_DIGITS-1:0]   w_sel_nxt;
  logic                    r_write;
  logic                    w_write_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    r_overflow;
  logic                    w_overflow_nxt;
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
  logic                    r_blank;
  logic                    w_blank_nxt;
`endif

  logic [63:0]             w_value_wide;
  logic [BCD_W-1:0]        w_adj;
  logic [BCD_W+BIN_W-1:0]  w_cat;
  logic [BCD_W-1:0]        w_conv;
  logic [BCD_W-1:0]        w_bcd_rest;

  assign w_value_wide = 64'(value_i);

  bcd_shift_add3 #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_adj (
    .i_bcd (r_bcd),
    .o_bcd (w_adj)
  );

  // One double-dabble step: corrected BCD and the binary shifter move left
  // together; the top BCD bit falls off (cannot be set for in-range values).
  assign w_cat      = {w_adj, r_shift} << 1;
  assign w_conv     = w_cat[BCD_W+BIN_W-1:BIN_W];
  // During WRITE, r_bcd holds the displayed digit in nibble 0; the
  // remaining digits slide down one nibble per strobe.
  assign w_bcd_rest = r_bcd >> 4;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bcd_nxt      = r_bcd;
    w_cnt_nxt      = r_cnt;
    w_digit_nxt    = r_digit;
    w_sel_nxt      = '0;
    w_write_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_overflow_nxt = r_overflow;
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
    w_blank_nxt    = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (value_valid) begin
          if (w_value_wide > MAXVAL) begin
            w_state_nxt    = DONE;
            w_done_nxt     = 1'b1;
            w_overflow_nxt = 1'b1;
          end else begin
            w_state_nxt    = CONVERT;
            w_shift_nxt    = value_i;
            w_bcd_nxt      = '0;
            w_cnt_nxt      = '0;
            w_overflow_nxt = 1'b0;
          end
        end
      end

      CONVERT: begin
        w_bcd_nxt   = w_conv;
        w_shift_nxt = w_cat[BIN_W-1:0];
        if (r_cnt == CONV_LAST) begin
          // Conversion finishes on this edge; present digit 0 immediately.
          w_state_nxt = WRITE;
          w_cnt_nxt   = '0;
          w_write_nxt = 1'b1;
          w_sel_nxt   = NUM_DIGITS'(1);
          w_digit_nxt = w_conv[3:0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      WRITE: begin
        if (r_cnt == WRITE_LAST) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_bcd_nxt   = w_bcd_rest;
          w_write_nxt = 1'b1;
          w_sel_nxt   = r_sel << 1;
          w_digit_nxt = w_bcd_rest[3:0];
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
          // Leading zero: this digit and everything above it are zero.
          w_blank_nxt = (w_bcd_rest == '0);
`endif
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // and kept out of the sensitivity list.
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_digit    <= '0;
      r_sel      <= '0;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
      r_blank    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bcd      <= w_bcd_nxt;
      r_cnt      <= w_cnt_nxt;
      r_digit    <= w_digit_nxt;
      r_sel      <= w_sel_nxt;
      r_write    <= w_write_nxt;
      r_done     <= w_done_nxt;
      r_overflow <= w_overflow_nxt;
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
      r_blank    <= w_blank_nxt;
`endif
    end
  end

  assign value_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign digit_o     = r_digit;
  assign digit_sel   = r_sel;
  assign digit_write = r_write;
  assign done        = r_done;
  assign overflow    = r_overflow;
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
  assign digit_blank = r_blank;
`endif

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl. Stimulus pushes the expected
// digit strobes and done pulse (with the cycle they must appear in) for
// every accepted value; a negedge monitor pops and compares them.
// Define BCD_DISPLAY_CTRL_BLANK_EN to also check digit_blank.
module tb_bcd_display_ctrl;

  localparam int N  = 4;
  localparam int BW = 14;

  typedef struct {
    int           cyc;
    bit           is_done;
    logic [N-1:0] sel;
    logic [3:0]   digit;
    bit           blank;
  } ev_t;

  logic          clk;
  logic          reset;
  logic [BW-1:0] value_i;
  logic          value_valid;
  logic          value_ready;
  logic [3:0]    digit_o;
  logic [N-1:0]  digit_sel;
  logic          digit_write;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
  logic          digit_blank;
`endif

  bcd_display_ctrl #(
    .NUM_DIGITS (N),
    .BIN_W      (BW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value_i     (value_i),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit_o     (digit_o),
    .digit_sel   (digit_sel),
    .digit_write (digit_write),
    .busy        (busy),
    .done        (done),
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
    .digit_blank (digit_blank),
`endif
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t             sb[$];
  int              n_vec = 0;
  int              n_err = 0;
  bit              mon_en = 1'b0;
  bit              exp_ready = 1'b1;
  int              ready_cyc = 0;
  int              ovf_cyc = 0;
  bit              ovf_old = 1'b0;
  bit              ovf_new = 1'b0;
  int              last_t = 0;
  longint unsigned maxv;
  longint unsigned mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: decimal digits by division, timing from the cycle
  // budget of conversion and write phases.
  task automatic model_transfer(input int t, input longint unsigned v);
    ev_t             e;
    longint unsigned p;
    last_t  = t;
    ovf_old = ovf_new;
    ovf_new = (v > maxv);
    ovf_cyc = t;
    if (v > maxv) begin
      e = '{cyc: t, is_done: 1'b1, sel: '0, digit: 4'd0, blank: 1'b0};
      sb.push_back(e);
      ready_cyc = t + 1;
    end else begin
      p = 1;
      for (int k = 0; k < N; k++) begin
        e.cyc     = t + BW + k;
        e.is_done = 1'b0;
        e.sel     = N'(1) << k;
        e.digit   = 4'((v / p) % 10);
        e.blank   = (k > 0) && (v < p);
        sb.push_back(e);
        p = p * 10;
      end
      e = '{cyc: t + BW + N, is_done: 1'b1, sel: '0, digit: 4'd0, blank: 1'b0};
      sb.push_back(e);
      ready_cyc = t + BW + N + 1;
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge.
  task automatic step(input bit vld, input longint unsigned v, output bit xfer);
    @(posedge clk);
    #2;
    v           = v & mask;
    value_valid = vld;
    value_i     = BW'(v);
    exp_ready   = (cyc >= ready_cyc);
    xfer        = vld && exp_ready;
    if (xfer) model_transfer(cyc + 1, v);
  endtask

  task automatic send(input longint unsigned v);
    bit sent;
    sent = 1'b0;
    for (int i = 0; i < 200 && !sent; i++) step(1'b1, v, sent);
    check("send_accepted", 64'(sent), 64'd1);
  endtask

  function automatic longint unsigned rand_val();
    case ($urandom % 4)
      0: return longint'($urandom) % (maxv + 1);
      1: return (maxv < mask) ? longint'($urandom_range(32'(mask), 32'(maxv + 1)))
                              : longint'($urandom) & mask;
      2: return longint'($urandom % 100);
      default: return longint'($urandom) & mask;
    endcase
  endfunction

  task automatic check_reset_values();
    check("rst_ready", 64'(value_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_digit", 64'(digit_o), 64'd0);
    check("rst_sel", 64'(digit_sel), 64'd0);
    check("rst_write", 64'(digit_write), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
  endtask

  // Monitor: handshake/status every cycle, scoreboard on strobes and done.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      check("value_ready", 64'(value_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(!exp_ready));
      check("overflow", 64'(overflow), 64'((cyc >= ovf_cyc) ? ovf_new : ovf_old));
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missed_event at cyc %0d: got nothing, expected %s in cyc %0d",
                 cyc, sb[0].is_done ? "done" : "digit_write", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (digit_write || done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output at cyc %0d: got write=%0b done=%0b, expected none",
                   cyc, digit_write, done);
        end else begin
          e = sb.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          check("done", 64'(done), 64'(e.is_done));
          check("digit_write", 64'(digit_write), 64'(!e.is_done));
          check("digit_sel", 64'(digit_sel), 64'(e.sel));
          if (!e.is_done) begin
            check("digit_o", 64'(digit_o), 64'(e.digit));
`ifdef BCD_DISPLAY_CTRL_BLANK_EN
            check("digit_blank", 64'(digit_blank), 64'(e.blank));
`endif
          end
        end
      end else begin
        check("idle_sel", 64'(digit_sel), 64'd0);
      end
    end
  end

  initial begin
    bit x;
    longint unsigned p10;
    p10 = 1;
    for (int k = 0; k < N; k++) p10 = p10 * 10;
    mask = (64'd1 << BW) - 1;
    maxv = (p10 - 1 < mask) ? p10 - 1 : mask;

    reset       = 1'b1;
    value_valid = 1'b0;
    value_i     = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    check_reset_values();
    ready_cyc = cyc;
    exp_ready = 1'b1;
    mon_en    = 1'b1;

    // Directed values, including range boundaries.
    send(1234);
    send(10000);
    send(7);
    send(0);
    send(9999);
    send(45);
    send(maxv + 1);
    send(mask);

    // Random values with random valid gaps.
    for (int i = 0; i < 300; i++) step(($urandom % 2) == 1, rand_val(), x);

    // Valid held high continuously with a new value every cycle.
    for (int i = 0; i < 200; i++) step(1'b1, rand_val(), x);

    // Reset during WRITE, right after the second strobe is presented.
    send(1234);
    for (int i = 0; i < 100 && cyc != last_t + BW + 1; i++) step(1'b0, 0, x);
    check("reached_second_strobe", 64'(cyc), 64'(last_t + BW + 1));
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset       = 1'b0;
    value_valid = 1'b0;
    sb.delete();
    ready_cyc = cyc;
    exp_ready = 1'b1;
    ovf_old   = 1'b0;
    ovf_new   = 1'b0;
    ovf_cyc   = 0;
    check_reset_values();
    for (int i = 0; i < 30; i++) step(1'b0, 0, x);
    send(7);

    // Drain outstanding expectations.
    for (int i = 0; i < 100 && sb.size() > 0; i++) step(1'b0, 0, x);
    step(1'b0, 0, x);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
- Sequencer sitting in front of a bank of NUM_DIGITS registered seven-segment decoder units. Each unit accepts one 4-bit digit per clock when its write strobe is high.
- Accepts a binary result over a valid/ready handshake and converts it serially to BCD (shift-add-3, one bit per cycle).
- Then writes one digit per cycle to the decoder bank, least-significant digit first, and pulses done.
- Out-of-range values are flagged and not written.

Parameters:
- NUM_DIGITS, 4, number of decimal digits/display units (1..8).
- BIN_W, 14, width of the binary input (1..32).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- value_i  in  BIN_W  unsigned binary value to display.
- value_valid  in  1  value_i valid.
- value_ready  out  1  block can accept a value (high only in IDLE).
- digit_o  out  4  BCD digit presented to the decoder bank.
- digit_sel  out  NUM_DIGITS  one-hot select of the target display unit; bit 0 is the least-significant digit.
- digit_write  out  1  write strobe. Each unit's write enable is digit_write AND digit_sel[i].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of each transaction.
- overflow  out  1  last accepted value exceeded 10^NUM_DIGITS-1; sticky until the next accept.

Behaviour:
- Reset values: value_ready=1 (state IDLE); digit_o=0; digit_sel=0; digit_write=0; busy=0; done=0; overflow=0. The internal shift and BCD registers are cleared.
- Handshake: a transfer occurs when value_valid && value_ready at a rising edge (cycle T). value_i is captured at T; later changes are ignored. value_valid while busy is ignored; no queueing.
- States: IDLE, CONVERT, WRITE, DONE.
- IDLE -> CONVERT on transfer, if value_i <= MAXVAL. MAXVAL = 10^NUM_DIGITS-1, saturated to 2^BIN_W-1.
- IDLE -> DONE on transfer, if value_i > MAXVAL. In this case overflow is set to 1 at T+1 and no digit_write is issued.
- Any transfer with value_i <= MAXVAL clears overflow at T+1.
- CONVERT lasts exactly BIN_W cycles (T+1..T+BIN_W). Each cycle:
  - every BCD nibble >= 5 gets +3;
  - then {bcd, shift} shifts left by 1.
  - The BCD register is 4*NUM_DIGITS bits wide. Carries beyond the top nibble cannot occur, by the MAXVAL check.
- WRITE lasts exactly NUM_DIGITS cycles (T+BIN_W+1 .. T+BIN_W+NUM_DIGITS). In cycle k (k = 0..NUM_DIGITS-1):
  - digit_write=1;
  - digit_sel = 1<<k;
  - digit_o = BCD nibble k.
  - Leading zeros are written as 0 unless the optional feature is enabled.
- DONE lasts one cycle: done=1, digit_write=0, digit_sel=0. Then the state returns to IDLE.
- Latencies:
  - in-range value: done at T+BIN_W+NUM_DIGITS+1;
  - overflow: done at T+1.
  - value_ready rises the cycle after done, so back-to-back transfers are at most one per BIN_W+NUM_DIGITS+2 cycles.
- Outputs are registered; digit_o, digit_sel and digit_write change only at clock edges.
- Reset mid-operation: reset has priority over everything. The state returns to IDLE next edge, any WRITE sequence is aborted, and no further strobes are issued. Display contents already written are the decoder units' own concern.
- Value 0 is a legal input: all NUM_DIGITS digits are written as 0.

Optional Feature:
- Macro: BCD_DISPLAY_CTRL_BLANK_EN.
- With the macro defined:
  - extra output port digit_blank (out, 1), valid with digit_write;
  - digit_blank=1 for each digit more significant than the highest nonzero digit;
  - digit 0 is never blanked, so value 0 shows a single "0";
  - the integrator routes digit_blank AND digit_sel[i] into unit i's reset, which blanks that display.
- Without the macro: the port is absent and all digits are written as decimal values.

Decomposition:
- Shared package bcd_display_pkg:
  - state enum type (IDLE, CONVERT, WRITE, DONE);
  - constant function pow10(n) for MAXVAL;
  - nibble adjust function add3_if_ge5.
- One natural sub-module: bcd_shift_add3, the NUM_DIGITS-wide combinational adjust stage. It is instantiated once inside the CONVERT datapath.

Test Plan:
- Reset, then value 1234 (BIN_W=14, NUM_DIGITS=4) -> ready drops at T+1; writes at T+15..T+18 with (sel=0001,digit=4), (0010,3), (0100,2), (1000,1); done at T+19; overflow=0.
- Value 10000 -> overflow=1 at T+1; done at T+1; zero digit_write pulses. Next value 7 -> overflow clears at T+1; digits 7,0,0,0 written.
- Value 0 and value 9999 -> digits 0,0,0,0 and 9,9,9,9 respectively; with BCD_DISPLAY_CTRL_BLANK_EN, value 0 writes digit_blank pattern 0,1,1,1 (digit 0 first) and value 9999 writes 0,0,0,0.
- value_valid held high continuously with changing values -> only values present when ready=1 are accepted; one transfer per 20 cycles; no strobes overlap.
- Reset asserted during WRITE after the second strobe -> no further digit_write after the reset edge; all outputs at reset values; ready=1 on the following cycle.
- Feature enabled, value 45 -> digit_blank pattern 0,0,1,1 (digits 5,4,0,0).
